// File: rtl/isqrt_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : isqrt_arb_pkg
// Purpose  : Shared defaults and types for the isqrt request arbiter.
//            tag_t identifies which requester owns an in-flight operation.
//            It is sized for the largest supported requester count (8),
//            so the same type fits every legal N_REQ.
// Revision : 1.0 - initial release
// ============================================================================
package isqrt_arb_pkg;

  localparam int c_N_REQ_DEF = 4;
  localparam int c_DEPTH_DEF = 16;
  localparam int c_MAX_N_REQ = 8;
  localparam int c_TAG_W     = $clog2(c_MAX_N_REQ);

  typedef logic [c_TAG_W-1:0] tag_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Round-robin arbiter. The grant goes to the first asserted
//            request strictly after the last winner, wrapping modulo N_REQ.
//            The pointer moves to the winner only when advance is high.
// Ports    : clk, rst      - clock, asynchronous active-high reset
//            req[N_REQ]    - request vector
//            advance       - the current grant was accepted this cycle
//            grant[N_REQ]  - one-hot (or zero) grant, combinational
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter
  import isqrt_arb_pkg::*;
#(
  parameter int N_REQ = c_N_REQ_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             advance,
  output logic [N_REQ-1:0] grant
);

  tag_t r_ptr;
  tag_t w_gidx;
  logic w_found;

  // Scan from ptr+1 around to ptr itself, so the last winner has lowest
  // priority and a lone requester still wins every cycle.
  always_comb begin
    grant   = '0;
    w_found = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      int idx;
      idx = (int'(r_ptr) + k) % N_REQ;
      if (!w_found && req[idx]) begin
        grant[idx] = 1'b1;
        w_found    = 1'b1;
      end
    end
  end

  always_comb begin
    w_gidx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) w_gidx = tag_t'(i);
    end
  end

  // Reset to N_REQ-1 so requester 0 holds first priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= tag_t'(N_REQ - 1);
    end else if (advance) begin
      r_ptr <= w_gidx;
    end
  end

endmodule
`default_nettype wire

// File: rtl/isqrt_pipe_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : isqrt_pipe_arbiter
// Purpose  : Shares one pipelined, in-order isqrt unit among N_REQ
//            requesters. One request is issued per cycle under round-robin
//            arbitration. A tag FIFO records the owner of each in-flight
//            operation, and each result is routed back to its owner.
// Ports    : clk, rst              - clock, asynchronous active-high reset
//            req_vld/req_x/req_rdy - per-requester request handshake
//            rsp_vld/rsp_y         - one-hot result pulse, shared result bus
//            isqrt_x_vld/isqrt_x   - operand to the isqrt unit
//            isqrt_y_vld/isqrt_y   - result from the isqrt unit
//            err                   - sticky: result arrived with no tag queued
// Revision : 1.0 - initial release
// ============================================================================
module isqrt_pipe_arbiter
  import isqrt_arb_pkg::*;
#(
  parameter int N_REQ = c_N_REQ_DEF,
  parameter int DEPTH = c_DEPTH_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req_vld,
  input  logic [32*N_REQ-1:0] req_x,
  output logic [N_REQ-1:0]    req_rdy,
  output logic [N_REQ-1:0]    rsp_vld,
  output logic [15:0]         rsp_y,
  output logic                isqrt_x_vld,
  output logic [31:0]         isqrt_x,
  input  logic                isqrt_y_vld,
  input  logic [15:0]         isqrt_y,
  output logic                err
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = $clog2(DEPTH + 1);
  localparam logic [c_CNT_W-1:0] c_DEPTH_CNT = c_CNT_W'(DEPTH);

  logic [N_REQ-1:0]   w_grant;
  logic               w_can_issue;
  logic               w_push;
  logic               w_pop;
  logic               w_err_evt;
  tag_t               w_push_tag;
  tag_t               w_pop_tag;
  logic [31:0]        w_push_x;

  tag_t               r_mem [DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_CNT_W-1:0] r_count;

  // A result arriving this cycle frees its slot in the same cycle, so a
  // full FIFO can still accept. Gating with rst keeps req_rdy low while
  // the block is held in reset.
  assign w_can_issue = ~rst & ((r_count < c_DEPTH_CNT) | isqrt_y_vld);
  assign req_rdy     = w_grant & {N_REQ{w_can_issue}};
  assign w_push      = |req_rdy;

  // A tag pushed in this same cycle is not yet readable, so it cannot
  // satisfy a result. A result with an empty FIFO is an error.
  assign w_pop       = isqrt_y_vld & (r_count != '0);
  assign w_err_evt   = isqrt_y_vld & (r_count == '0);
  assign w_pop_tag   = r_mem[r_rd_ptr];

  rr_arbiter #(
    .N_REQ   (N_REQ)
  ) u_rr_arbiter (
    .clk     (clk),
    .rst     (rst),
    .req     (req_vld),
    .advance (w_push),
    .grant   (w_grant)
  );

  always_comb begin
    w_push_tag = '0;
    w_push_x   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_grant[i]) begin
        w_push_tag = tag_t'(i);
        w_push_x   = req_x[32*i +: 32];
      end
    end
  end

  // Tag storage needs no reset; validity is tracked by the count/pointers.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_push_tag;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      isqrt_x_vld <= 1'b0;
      isqrt_x     <= '0;
      rsp_vld     <= '0;
      rsp_y       <= '0;
      err         <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNT_W'(1);
        2'b01:   r_count <= r_count - c_CNT_W'(1);
        default: r_count <= r_count;
      endcase

      isqrt_x_vld <= w_push;
      if (w_push) isqrt_x <= w_push_x;

      rsp_vld <= w_pop ? ({{(N_REQ-1){1'b0}}, 1'b1} << w_pop_tag) : '0;
      if (w_pop) rsp_y <= isqrt_y;

      if (w_err_evt) err <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_isqrt_pipe_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_isqrt_pipe_arbiter
// Purpose  : Self-checking bench for isqrt_pipe_arbiter. It contains a
//            behavioural in-order isqrt pipeline with adjustable latency and
//            a scoreboard of expected owner, result and arrival cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_isqrt_pipe_arbiter;

  localparam int c_N   = 4;
  localparam int c_DEP = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [c_N-1:0]    req_vld;
  logic [32*c_N-1:0] req_x;
  logic [c_N-1:0]    req_rdy;
  logic [c_N-1:0]    rsp_vld;
  logic [15:0]       rsp_y;
  logic              isqrt_x_vld;
  logic [31:0]       isqrt_x;
  logic              isqrt_y_vld = 1'b0;
  logic [15:0]       isqrt_y = '0;
  logic              err;

  isqrt_pipe_arbiter #(.N_REQ(c_N), .DEPTH(c_DEP)) dut (
    .clk(clk), .rst(rst), .req_vld(req_vld), .req_x(req_x), .req_rdy(req_rdy),
    .rsp_vld(rsp_vld), .rsp_y(rsp_y), .isqrt_x_vld(isqrt_x_vld),
    .isqrt_x(isqrt_x), .isqrt_y_vld(isqrt_y_vld), .isqrt_y(isqrt_y), .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int lat_l    = 3;
  logic spur   = 1'b0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] sqrt_ref(input logic [31:0] x);
    longint r;
    r = 0;
    while ((r + 1) * (r + 1) <= longint'(x)) r++;
    return 16'(r);
  endfunction

  // ---------------- behavioural isqrt pipeline ----------------
  typedef struct { int due; logic [15:0] y; } iq_t;
  iq_t iq[$];
  int  mcyc_model = 0;

  always begin
    iq_t e;
    @(posedge clk); #1;
    mcyc_model++;
    isqrt_y_vld = 1'b0;
    if (rst) begin
      iq.delete();
    end else if (iq.size() > 0 && iq[0].due == mcyc_model) begin
      e = iq.pop_front();
      isqrt_y_vld = 1'b1;
      isqrt_y     = e.y;
    end
    if (spur) isqrt_y_vld = 1'b1;
  end

  always @(negedge clk) begin
    if (!rst && isqrt_x_vld) iq.push_back('{mcyc_model + lat_l, sqrt_ref(isqrt_x)});
  end

  // ---------------- monitor / scoreboard ----------------
  typedef struct { logic [c_N-1:0] oh; logic [15:0] y; int due; } exp_t;
  exp_t exp_q[$];
  int   hs_log[$];
  int   mcyc = 0;
  logic prev_hs = 1'b0;
  logic [31:0] prev_x = '0;

  always @(negedge clk) begin
    logic [c_N-1:0] hs;
    exp_t e;
    mcyc++;
    if (rst) begin
      exp_q.delete();
      prev_hs = 1'b0;
      check("rst_rdy",   32'(req_rdy), 0);
      check("rst_rsp",   32'(rsp_vld), 0);
      check("rst_rsp_y", 32'(rsp_y), 0);
      check("rst_x_vld", 32'(isqrt_x_vld), 0);
      check("rst_x",     isqrt_x, 0);
      check("rst_err",   32'(err), 0);
    end else begin
      check("x_vld", 32'(isqrt_x_vld), 32'(prev_hs));
      if (prev_hs) check("x_val", isqrt_x, prev_x);
      check("rdy_onehot", 32'($countones(req_rdy) <= 1), 1);
      check("rsp_onehot", 32'($countones(rsp_vld) <= 1), 1);
      if (rsp_vld != '0) begin
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", 32'(rsp_vld), 0);
        end else begin
          e = exp_q.pop_front();
          check("rsp_owner", 32'(rsp_vld), 32'(e.oh));
          check("rsp_y", 32'(rsp_y), 32'(e.y));
          check("rsp_latency", mcyc, e.due);
        end
      end
      hs = req_vld & req_rdy;
      prev_hs = 1'b0;
      for (int i = 0; i < c_N; i++) begin
        if (hs[i]) begin
          exp_q.push_back('{c_N'(1) << i, sqrt_ref(req_x[32*i +: 32]), mcyc + lat_l + 2});
          hs_log.push_back(i);
          prev_hs = 1'b1;
          prev_x  = req_x[32*i +: 32];
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step;
    @(posedge clk); #1;
  endtask

  task automatic drain(input int bound);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || iq.size() != 0) && k < bound) begin
      @(negedge clk);
      k++;
    end
    check("drain", exp_q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic single_req;
    step;
    req_x[95:64] = 32'd144;
    req_vld = 4'b0100;
    @(negedge clk);
    check("single_rdy", 32'(req_rdy), 32'h4);
    step;
    req_vld = '0;
    drain(60);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req_vld = '0; req_x = '0;
    repeat (3) @(posedge clk); #1;
    rst = 1'b0;

    // Fairness: all requesters continuously, requester 0 first after reset
    step;
    req_x = {32'd49, 32'd36, 32'd25, 32'd16};
    req_vld = 4'hF;
    hs_log.delete();
    repeat (16) @(negedge clk);
    step;
    req_vld = '0;
    check("fair_cnt", hs_log.size(), 16);
    for (int k = 0; k < 16 && k < hs_log.size(); k++) check("fair_order", hs_log[k], k % 4);
    drain(100);

    // Single request
    single_req();

    // Full throughput: latency DEPTH-1, requester 0 streams 0..31
    lat_l = c_DEP - 1;
    step;
    req_vld = 4'b0001;
    for (int k = 0; k < 32; k++) begin
      req_x[31:0] = k;
      @(negedge clk);
      check("thru_rdy", 32'(req_rdy[0]), 1);
      step;
    end
    req_vld = '0;
    drain(100);

    // FIFO full: latency 16, exactly DEPTH accepts then stall until pop
    lat_l = 16;
    step;
    req_x[63:32] = 32'd100;
    req_vld = 4'b0010;
    for (int j = 0; j < 18; j++) begin
      @(negedge clk);
      check("full_rdy", 32'(req_rdy[1]), 32'((j < c_DEP) || isqrt_y_vld));
      if (j == 17) check("full_pop_seen", 32'(isqrt_y_vld), 1);
      step;
    end
    req_vld = '0;
    drain(100);

    // Spurious result with empty FIFO
    @(negedge clk); spur = 1'b1;
    @(negedge clk); spur = 1'b0;
    @(negedge clk);
    check("spur_err", 32'(err), 1);
    check("spur_rsp", 32'(rsp_vld), 0);
    repeat (3) @(negedge clk);
    check("spur_sticky", 32'(err), 1);

    // Reset with five operations in flight
    step;
    req_vld = 4'b1000;
    for (int k = 0; k < 5; k++) begin
      req_x[127:96] = 32'(k * k + 3);
      @(negedge clk);
      check("mid_rdy", 32'(req_rdy[3]), 1);
      step;
    end
    req_vld = '0;
    repeat (3) step;
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_err", 32'(err), 0);
    step;
    rst = 1'b0;
    repeat (40) @(negedge clk);
    lat_l = 3;
    single_req();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
